// File: rtl/bit4_piso_tx_if.sv
// Parallel-load handshake and serial output bundle for bit4_piso_tx.
// The producer side drives d/load_valid; the transmitter drives everything else.
interface bit4_piso_tx_if;
    logic [3:0] d;
    logic       load_valid;
    logic       load_ready;
    logic       sout;
    logic       sout_valid;
    logic       frame_done;

    modport master (
        output d, load_valid,
        input  load_ready, sout, sout_valid, frame_done
    );

    modport slave (
        input  d, load_valid,
        output load_ready, sout, sout_valid, frame_done
    );
endinterface

// File: rtl/bit4_piso_tx.sv
// 4-bit parallel-in serial-out transmitter: start bit, 4 data bits LSB-first,
// optional even-parity bit (define BIT4_PISO_TX_PARITY_EN), stop bit.
//
// state  | meaning
// IDLE   | line high, ready for a word
// START  | start bit (low) on sout
// SHIFT  | data bits 0..3, indexed by cnt_q
// PARITY | even parity of captured word (BIT4_PISO_TX_PARITY_EN only)
// STOP   | stop bit (high), frame_done pulse
module bit4_piso_tx (
    input  logic                 clk,
    input  logic                 rst_n,
    bit4_piso_tx_if.slave        tx_if
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        SHIFT  = 3'd2,
`ifdef BIT4_PISO_TX_PARITY_EN
        PARITY = 3'd4,
`endif
        STOP   = 3'd3
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] shift_q, shift_d;
    logic [1:0] cnt_q, cnt_d;
    logic       sout_q, sout_d;
    logic       sout_valid_q, sout_valid_d;
    logic       frame_done_q, frame_done_d;
    logic       load_ready_q, load_ready_d;
    logic [1:0] nxt_idx;

    assign nxt_idx = cnt_q + 2'd1;

    // Outputs are computed for the state being entered so they are registered
    // alongside it and line up with state_q.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        sout_d       = 1'b1;
        sout_valid_d = 1'b0;
        frame_done_d = 1'b0;
        load_ready_d = 1'b0;
        case (state_q)
            IDLE: begin
                load_ready_d = 1'b1;
                if (tx_if.load_valid && load_ready_q) begin
                    shift_d      = tx_if.d;
                    state_d      = START;
                    sout_d       = 1'b0;
                    sout_valid_d = 1'b1;
                    load_ready_d = 1'b0;
                end
            end
            START: begin
                state_d      = SHIFT;
                cnt_d        = 2'd0;
                sout_d       = shift_q[0];
                sout_valid_d = 1'b1;
            end
            SHIFT: begin
                cnt_d        = nxt_idx;
                sout_valid_d = 1'b1;
                if (cnt_q == 2'd3) begin
`ifdef BIT4_PISO_TX_PARITY_EN
                    state_d      = PARITY;
                    sout_d       = ^shift_q;
`else
                    state_d      = STOP;
                    frame_done_d = 1'b1;
`endif
                end else begin
                    sout_d = shift_q[nxt_idx];
                end
            end
`ifdef BIT4_PISO_TX_PARITY_EN
            PARITY: begin
                state_d      = STOP;
                sout_valid_d = 1'b1;
                frame_done_d = 1'b1;
            end
`endif
            STOP: begin
                state_d      = IDLE;
                load_ready_d = 1'b1;
            end
            default: begin
                state_d      = IDLE;
                load_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            shift_q      <= 4'd0;
            cnt_q        <= 2'd0;
            sout_q       <= 1'b1;
            sout_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
            load_ready_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            sout_q       <= sout_d;
            sout_valid_q <= sout_valid_d;
            frame_done_q <= frame_done_d;
            load_ready_q <= load_ready_d;
        end
    end

    assign tx_if.sout       = sout_q;
    assign tx_if.sout_valid = sout_valid_q;
    assign tx_if.frame_done = frame_done_q;
    assign tx_if.load_ready = load_ready_q;

endmodule
